// File: rtl/scene_ctl.sv
// Game scene sequencer: MENU -> BATTLE -> ENDGAME -> MENU, with every scene change
// committed only on a vsync frame edge so a frame never mixes two scenes.
module scene_ctl #(
    parameter int unsigned ENDGAME_FRAMES = 180,
    parameter bit          VS_POL         = 1'b0
) (
    input  logic       i_pclk,
    input  logic       i_rst,
    input  logic       i_vs,
    input  logic       i_start,
    input  logic       i_battle_done,
    input  logic [1:0] i_winner,
    input  logic       i_restart,
    output logic [1:0] o_sel,
    output logic       o_battle_rst,
    output logic [1:0] o_winner,
    output logic       o_pending
);

    typedef enum logic [2:0] {
        MENU       = 3'd0,
        ARM_BATTLE = 3'd1,
        BATTLE     = 3'd2,
        ARM_END    = 3'd3,
        ENDGAME    = 3'd4,
        ARM_MENU   = 3'd5
    } state_t;

    localparam logic [1:0]  SEL_MENU    = 2'b00;
    localparam logic [1:0]  SEL_BATTLE  = 2'b01;
    localparam logic [1:0]  SEL_ENDGAME = 2'b10;
    localparam logic [11:0] FRAMES_MAX  = 12'(ENDGAME_FRAMES);

    state_t      state;
    logic [11:0] frame_cnt;
    logic        vs_q;
    logic        vs_act;
    logic        vs_q_act;
    logic        tick;

    // Tick marks the leading edge of the vsync pulse, whatever its polarity.
    assign vs_act   = (i_vs == VS_POL);
    assign vs_q_act = (vs_q == VS_POL);
    assign tick     = vs_act & ~vs_q_act;

    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            state        <= MENU;
            o_sel        <= SEL_MENU;
            o_battle_rst <= 1'b0;
            o_winner     <= '0;
            o_pending    <= 1'b0;
            frame_cnt    <= '0;
            vs_q         <= ~VS_POL;
        end else begin
            vs_q         <= i_vs;
            o_battle_rst <= 1'b0;
            case (state)
                MENU: begin
                    if (i_start) begin
                        state     <= ARM_BATTLE;
                        o_pending <= 1'b1;
                    end
                end
                ARM_BATTLE: begin
                    if (tick) begin
                        state        <= BATTLE;
                        o_sel        <= SEL_BATTLE;
                        o_battle_rst <= 1'b1;
                        o_pending    <= 1'b0;
                    end
                end
                BATTLE: begin
                    if (i_battle_done) begin
                        state     <= ARM_END;
                        o_winner  <= i_winner;
                        o_pending <= 1'b1;
                    end
                end
                ARM_END: begin
                    if (tick) begin
                        state     <= ENDGAME;
                        o_sel     <= SEL_ENDGAME;
                        o_pending <= 1'b0;
                        frame_cnt <= '0;
                    end
                end
                ENDGAME: begin
                    // Restart uses the count before this cycle's tick; early requests are dropped.
                    if (tick && (frame_cnt < FRAMES_MAX))
                        frame_cnt <= frame_cnt + 12'd1;
                    if (i_restart && (frame_cnt >= FRAMES_MAX)) begin
                        state     <= ARM_MENU;
                        o_pending <= 1'b1;
                    end
                end
                ARM_MENU: begin
                    if (tick) begin
                        state     <= MENU;
                        o_sel     <= SEL_MENU;
                        o_pending <= 1'b0;
                    end
                end
                default: begin
                    state     <= MENU;
                    o_sel     <= SEL_MENU;
                    o_pending <= 1'b0;
                end
            endcase
        end
    end

endmodule
